dtu_stream_ctrl: RTL and testbench

Sequencing controller for the LiTE-DTU output stream. It decodes the DTU-side commands from the synchronisation unit and the ADC calibration-busy flags. From these it selects, word by word, what the serializers carry: compressed datapath, ADC test-unit words, sync pattern, or idle. It also drives datapath flush, datapath hold and the ADC calibration handshake, and sits between the SyncUnit outputs and the DATA32/DATA32_ATU multiplexer in front of the serializers.

---
 rtl/dtu_ctrl_pkg.sv | 43 ++++
 rtl/dtu_cal_watchdog.sv | 46 ++++
 rtl/dtu_stream_ctrl.sv | 157 +++++++++++++++
 tb/tb_dtu_stream_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtu_ctrl_pkg.sv
// ============================================================================
// dtu_ctrl_pkg : shared encodings for the LiTE-DTU stream controller
// Rev 1.0
// ============================================================================
`default_nettype none

package dtu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_SYNC     = 3'd0,
    ST_RUN      = 3'd1,
    ST_TEST     = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_CAL_REQ  = 3'd4,
    ST_CAL_WAIT = 3'd5,
    ST_CAL_DONE = 3'd6
  } state_t;

  localparam logic [1:0] SRC_DP   = 2'd0;
  localparam logic [1:0] SRC_ATU  = 2'd1;
  localparam logic [1:0] SRC_SYNC = 2'd2;
  localparam logic [1:0] SRC_IDLE = 2'd3;

  localparam logic [31:0] SYNC_PATTERN_DEFAULT = 32'hEAAAAAAA;

  function automatic logic [1:0] src_of(input state_t s);
    case (s)
      ST_SYNC: src_of = SRC_SYNC;
      ST_RUN:  src_of = SRC_DP;
      ST_TEST: src_of = SRC_ATU;
      default: src_of = SRC_IDLE;
    endcase
  endfunction

  function automatic state_t home_state(input logic sync_mode, input logic test_en);
    if (sync_mode)    home_state = ST_SYNC;
    else if (test_en) home_state = ST_TEST;
    else              home_state = ST_RUN;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dtu_cal_watchdog.sv
// ============================================================================
// dtu_cal_watchdog : calibration cycle counter, busy tracking and timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module dtu_cal_watchdog
  import dtu_ctrl_pkg::*;
#(
  parameter int CAL_TIMEOUT = 1023,
  parameter int TW          = 10
) (
  input  logic       clock,
  input  logic       rst_b,
  input  logic       clear,
  input  logic       run,
  input  logic [1:0] cal_busy,
  output logic       done,
  output logic       expired
);

  localparam logic [TW-1:0] LIMIT = TW'(CAL_TIMEOUT);

  logic [TW-1:0] count;
  logic          busy_seen;

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      count     <= '0;
      busy_seen <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      busy_seen <= 1'b0;
    end else if (run) begin
      // Saturate at the limit so a late exit can never wrap into a fresh window.
      if (count != LIMIT) count <= count + 1'b1;
      if (|cal_busy)      busy_seen <= 1'b1;
    end
  end

  assign done    = busy_seen && (cal_busy == 2'b00);
  assign expired = (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/dtu_stream_ctrl.sv
// ============================================================================
// dtu_stream_ctrl : selects serializer word source and sequences flush/calibration
// Rev 1.0
// ============================================================================
`default_nettype none

module dtu_stream_ctrl
  import dtu_ctrl_pkg::*;
#(
  parameter logic [31:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
  parameter int          FLUSH_WORDS  = 4,
  parameter int          CAL_TIMEOUT  = 1023,
  parameter int          TW           = 10
) (
  input  logic        clock,
  input  logic        rst_b,
  input  logic        handshake,
  input  logic        cmd_sync_mode,
  input  logic        cmd_flush,
  input  logic        cmd_adc_cal,
  input  logic        test_enable,
  input  logic [1:0]  cal_busy,
  output logic [1:0]  src_sel,
  output logic [31:0] sync_word,
  output logic        adc_cal_start,
  output logic        fifo_flush,
  output logic        dp_hold,
  output logic        cal_timeout,
  output logic [2:0]  state
);

  localparam logic [3:0] LAST_WORD = 4'(FLUSH_WORDS - 1);

  state_t     state_q;
  state_t     state_d;
  state_t     home;
  state_t     svc;
  logic       pend_flush_q;
  logic       pend_cal_q;
  logic [3:0] word_cnt_q;
  logic       want_flush;
  logic       want_cal;
  logic       in_cal;
  logic       enter;
  logic       set_timeout;
  logic       enter_flush;
  logic       enter_cal_req;
  logic       wd_done;
  logic       wd_expired;

  assign home       = home_state(cmd_sync_mode, test_enable);
  assign in_cal     = state_q inside {ST_CAL_REQ, ST_CAL_WAIT, ST_CAL_DONE};
  // A command arriving with the deciding handshake is already pending.
  assign want_flush = pend_flush_q | cmd_flush;
  assign want_cal   = pend_cal_q | (cmd_adc_cal & ~in_cal);
  assign svc        = want_flush ? ST_FLUSH : (want_cal ? ST_CAL_REQ : home);

  always_comb begin
    state_d     = state_q;
    enter       = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      ST_SYNC, ST_RUN, ST_TEST: begin
        if (handshake) begin
          state_d = svc;
          enter   = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (handshake && (word_cnt_q == LAST_WORD)) begin
          state_d = svc;
          enter   = 1'b1;
        end
      end
      ST_CAL_REQ: begin
        state_d = ST_CAL_WAIT;
        enter   = 1'b1;
      end
      ST_CAL_WAIT: begin
        if (wd_done) begin
          state_d = ST_CAL_DONE;
          enter   = 1'b1;
        end else if (wd_expired) begin
          state_d     = ST_CAL_DONE;
          enter       = 1'b1;
          set_timeout = 1'b1;
        end
      end
      ST_CAL_DONE: begin
        if (handshake) begin
          state_d = want_flush ? ST_FLUSH : home;
          enter   = 1'b1;
        end
      end
      default: begin
        state_d = ST_SYNC;
        enter   = 1'b1;
      end
    endcase
  end

  assign enter_flush   = enter && (state_d == ST_FLUSH);
  assign enter_cal_req = enter && (state_d == ST_CAL_REQ);

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= ST_SYNC;
      pend_flush_q  <= 1'b0;
      pend_cal_q    <= 1'b0;
      word_cnt_q    <= 4'd0;
      src_sel       <= SRC_SYNC;
      adc_cal_start <= 1'b0;
      fifo_flush    <= 1'b0;
      dp_hold       <= 1'b0;
      cal_timeout   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= enter_flush ? 1'b0 : want_flush;
      pend_cal_q   <= enter_cal_req ? 1'b0 : want_cal;

      if (enter_flush)
        word_cnt_q <= 4'd0;
      else if ((state_q == ST_FLUSH) && handshake)
        word_cnt_q <= word_cnt_q + 4'd1;

      // Outputs follow the next state so they line up with the state register.
      src_sel       <= src_of(state_d);
      dp_hold       <= (state_d == ST_CAL_REQ) || (state_d == ST_CAL_WAIT);
      adc_cal_start <= enter_cal_req;
      fifo_flush    <= enter && ((state_d == ST_FLUSH) || (state_d == ST_CAL_DONE));

      if (state_q == ST_CAL_REQ)
        cal_timeout <= 1'b0;
      else if (set_timeout)
        cal_timeout <= 1'b1;
    end
  end

  dtu_cal_watchdog #(
    .CAL_TIMEOUT (CAL_TIMEOUT),
    .TW          (TW)
  ) u_watchdog (
    .clock    (clock),
    .rst_b    (rst_b),
    .clear    (state_q == ST_CAL_REQ),
    .run      (state_q == ST_CAL_WAIT),
    .cal_busy (cal_busy),
    .done     (wd_done),
    .expired  (wd_expired)
  );

  assign sync_word = SYNC_PATTERN;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_dtu_stream_ctrl.sv
// ============================================================================
// tb_dtu_stream_ctrl : directed + randomized bench with a service-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dtu_stream_ctrl;

  localparam logic [31:0] SYNC_PATTERN = 32'hEAAAAAAA;
  localparam int          FLUSH_WORDS  = 4;
  localparam int          CAL_TIMEOUT  = 1023;
  localparam int          TW           = 10;
  localparam logic [8:0]  RESET_VEC    = {3'd0, 2'd2, 4'b0000};

  logic        clock = 1'b0;
  logic        rst_b;
  logic        handshake;
  logic        cmd_sync_mode;
  logic        cmd_flush;
  logic        cmd_adc_cal;
  logic        test_enable;
  logic [1:0]  cal_busy;
  logic [1:0]  src_sel;
  logic [31:0] sync_word;
  logic        adc_cal_start;
  logic        fifo_flush;
  logic        dp_hold;
  logic        cal_timeout;
  logic [2:0]  state;
  logic [8:0]  dut_vec;

  always #5 clock = ~clock;

  dtu_stream_ctrl #(
    .SYNC_PATTERN (SYNC_PATTERN),
    .FLUSH_WORDS  (FLUSH_WORDS),
    .CAL_TIMEOUT  (CAL_TIMEOUT),
    .TW           (TW)
  ) dut (
    .clock         (clock),
    .rst_b         (rst_b),
    .handshake     (handshake),
    .cmd_sync_mode (cmd_sync_mode),
    .cmd_flush     (cmd_flush),
    .cmd_adc_cal   (cmd_adc_cal),
    .test_enable   (test_enable),
    .cal_busy      (cal_busy),
    .src_sel       (src_sel),
    .sync_word     (sync_word),
    .adc_cal_start (adc_cal_start),
    .fifo_flush    (fifo_flush),
    .dp_hold       (dp_hold),
    .cal_timeout   (cal_timeout),
    .state         (state)
  );

  assign dut_vec = {state, src_sel, fifo_flush, adc_cal_start, dp_hold, cal_timeout};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: activities and services ----------------
  typedef enum int {M_HOME, M_FLUSH, M_CALREQ, M_CALWAIT, M_CALDONE} act_t;

  act_t m_act = M_HOME;
  int   m_home = 0;          // state code of the home mode being shown
  int   m_words_left = 0;
  int   m_wait_start = 0;
  int   cyc = 0;
  bit   m_want_flush = 0, m_want_cal = 0, m_seen = 0, m_tout = 0;
  bit   m_flush_pulse = 0, m_start_pulse = 0, m_calling = 0;

  function automatic int home_code();
    return cmd_sync_mode ? 0 : (test_enable ? 2 : 1);
  endfunction

  function automatic act_t next_service();
    return m_want_flush ? M_FLUSH : (m_want_cal ? M_CALREQ : M_HOME);
  endfunction

  task automatic m_begin(input act_t a);
    m_act = a;
    case (a)
      M_HOME:    m_home = home_code();
      M_FLUSH:   begin m_want_flush = 0; m_words_left = FLUSH_WORDS; m_flush_pulse = 1; end
      M_CALREQ:  begin m_want_cal = 0; m_start_pulse = 1; end
      M_CALWAIT: begin m_wait_start = cyc; m_seen = 0; m_tout = 0; end
      M_CALDONE: m_flush_pulse = 1;
      default:   ;
    endcase
  endtask

  function automatic logic [8:0] exp_vec();
    logic [2:0] sc;
    logic [1:0] src;
    case (m_act)
      M_HOME:    sc = 3'(m_home);
      M_FLUSH:   sc = 3'd3;
      M_CALREQ:  sc = 3'd4;
      M_CALWAIT: sc = 3'd5;
      default:   sc = 3'd6;
    endcase
    if (m_act == M_HOME) src = (m_home == 0) ? 2'd2 : ((m_home == 1) ? 2'd0 : 2'd1);
    else                 src = 2'd3;
    return {sc, src, m_flush_pulse, m_start_pulse,
            (m_act == M_CALREQ) || (m_act == M_CALWAIT), m_tout};
  endfunction

  always @(posedge clock) begin
    cyc++;
    m_flush_pulse = 0;
    m_start_pulse = 0;
    if (!rst_b) begin
      m_act = M_HOME; m_home = 0; m_want_flush = 0; m_want_cal = 0;
      m_seen = 0; m_tout = 0;
    end else begin
      m_calling = (m_act == M_CALREQ) || (m_act == M_CALWAIT) || (m_act == M_CALDONE);
      if (cmd_flush) m_want_flush = 1;
      if (cmd_adc_cal && !m_calling) m_want_cal = 1;
      case (m_act)
        M_HOME:   if (handshake) m_begin(next_service());
        M_FLUSH:  if (handshake) begin
                    m_words_left--;
                    if (m_words_left == 0) m_begin(next_service());
                  end
        M_CALREQ: m_begin(M_CALWAIT);
        M_CALWAIT: begin
          if (m_seen && cal_busy == 2'b00) m_begin(M_CALDONE);
          else if (cyc - m_wait_start == CAL_TIMEOUT + 1) begin
            m_begin(M_CALDONE);
            m_tout = 1;
          end else if (cal_busy != 2'b00) m_seen = 1;
        end
        M_CALDONE: if (handshake) m_begin(m_want_flush ? M_FLUSH : M_HOME);
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle checker and event monitors ----------------
  bit chk_on = 0;
  int n_start = 0, n_flush = 0, n_idle_hs = 0;

  always @(negedge clock) begin
    if (chk_on) begin
      if (!rst_b) check_eq("reset_outs", 32'(dut_vec), 32'(RESET_VEC));
      else        check_eq("cycle_outs", 32'(dut_vec), 32'(exp_vec()));
    end
    if (adc_cal_start) n_start++;
    if (fifo_flush)    n_flush++;
    if (handshake && src_sel == 2'd3) n_idle_hs++;
  end

  // ---------------- handshake generator ----------------
  bit hs_rand = 0;
  initial begin
    int hs_cnt;
    int hs_gap;
    hs_cnt = 0;
    hs_gap = 4;
    handshake = 1'b0;
    forever begin
      @(posedge clock); #2;
      hs_cnt++;
      handshake = 1'b0;
      if (hs_cnt >= hs_gap) begin
        handshake = 1'b1;
        hs_cnt    = 0;
        hs_gap    = hs_rand ? int'($urandom_range(2, 5)) : 4;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic pulse_flush();
    cmd_flush = 1'b1; step(1); cmd_flush = 1'b0;
  endtask

  task automatic pulse_cal();
    cmd_adc_cal = 1'b1; step(1); cmd_adc_cal = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin @(negedge clock); n++; end
    check_eq(tag, 32'(state), 32'(s));
    @(posedge clock); #2;
  endtask

  task automatic wait_home(input int budget, input string tag);
    int n = 0;
    while (state > 3'd2 && n < budget) begin @(negedge clock); n++; end
    check_eq(tag, 32'(state <= 3'd2), 32'd1);
    @(posedge clock); #2;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    int b_start, b_flush, b_idle, n, r;
    rst_b = 1'b1; cmd_sync_mode = 1'b1; test_enable = 1'b0;
    cmd_flush = 1'b0; cmd_adc_cal = 1'b0; cal_busy = 2'b00;
    #1 rst_b = 1'b0;
    step(3);
    chk_on = 1;
    step(2);
    rst_b = 1'b1;
    check_eq("sync_word", sync_word, SYNC_PATTERN);

    // Sync mode, then normal running
    step(12);
    check_eq("sync_src", 32'(src_sel), 32'd2);
    check_eq("sync_state", 32'(state), 32'd0);
    cmd_sync_mode = 1'b0;
    wait_state(3'd1, 20, "to_run");
    check_eq("run_src", 32'(src_sel), 32'd0);

    // Flush in RUN
    b_flush = n_flush; b_idle = n_idle_hs;
    pulse_flush();
    wait_state(3'd3, 20, "enter_flush");
    wait_state(3'd1, 60, "flush_back");
    check_eq("flush_words", 32'(n_idle_hs - b_idle), 32'(FLUSH_WORDS));
    check_eq("flush_pulses", 32'(n_flush - b_flush), 32'd1);
    check_eq("flush_src", 32'(src_sel), 32'd0);

    // Calibration from TEST with busy for 50 cycles
    test_enable = 1'b1;
    wait_state(3'd2, 20, "to_test");
    b_start = n_start; b_flush = n_flush;
    pulse_cal();
    wait_state(3'd5, 40, "cal_wait");
    cal_busy = 2'b11;
    step(50);
    cal_busy = 2'b00;
    wait_state(3'd2, 40, "cal_home");
    check_eq("cal_src", 32'(src_sel), 32'd1);
    check_eq("cal_tout0", 32'(cal_timeout), 32'd0);
    check_eq("cal_starts", 32'(n_start - b_start), 32'd1);
    check_eq("cal_flush", 32'(n_flush - b_flush), 32'd1);

    // Timeout with busy never asserted
    b_flush = n_flush;
    pulse_cal();
    n = 0;
    while (!adc_cal_start && n < 40) begin @(negedge clock); n++; end
    check_eq("tout_start_seen", 32'(adc_cal_start), 32'd1);
    n = 0;
    while (!cal_timeout && n < 2000) begin @(negedge clock); n++; end
    check_eq("tout_latency", 32'(n), 32'(CAL_TIMEOUT + 2));
    @(posedge clock); #2;
    wait_state(3'd2, 40, "tout_home");
    check_eq("tout_flag", 32'(cal_timeout), 32'd1);
    check_eq("tout_flush", 32'(n_flush - b_flush), 32'd1);
    pulse_cal();
    wait_state(3'd5, 40, "tout_again");
    check_eq("tout_clear", 32'(cal_timeout), 32'd0);
    cal_busy = 2'b01;
    step(5);
    cal_busy = 2'b00;
    wait_state(3'd2, 40, "tout_again_home");

    // Flush and calibration together; extra request during CAL_WAIT dropped
    b_start = n_start; b_flush = n_flush;
    cmd_flush = 1'b1; cmd_adc_cal = 1'b1;
    step(1);
    cmd_flush = 1'b0; cmd_adc_cal = 1'b0;
    n = 0;
    while (state == 3'd2 && n < 20) begin @(negedge clock); n++; end
    check_eq("svc_order", 32'(state), 32'd3);
    @(posedge clock); #2;
    wait_state(3'd5, 80, "cal_after_flush");
    pulse_cal();
    cal_busy = 2'b10;
    step(10);
    cal_busy = 2'b00;
    wait_state(3'd2, 40, "both_home");
    check_eq("both_starts", 32'(n_start - b_start), 32'd1);
    check_eq("both_flushes", 32'(n_flush - b_flush), 32'd2);

    // Reset in the middle of CAL_WAIT
    pulse_cal();
    wait_state(3'd5, 40, "rst_cal_wait");
    cal_busy = 2'b11;
    step(10);
    rst_b = 1'b0;
    #1;
    check_eq("async_rst", 32'(dut_vec), 32'(RESET_VEC));
    @(posedge clock); #2;
    step(2);
    cal_busy = 2'b00;
    b_start = n_start; b_flush = n_flush;
    rst_b = 1'b1;
    step(30);
    check_eq("rst_no_start", 32'(n_start - b_start), 32'd0);
    check_eq("rst_no_flush", 32'(n_flush - b_flush), 32'd0);

    // Randomized traffic, checked cycle by cycle against the model
    hs_rand = 1;
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 5));
      case (r)
        0: step(int'($urandom_range(1, 10)));
        1: pulse_flush();
        2, 4: begin
          wait_home(1200, "rnd_home");
          if (r == 4) cmd_flush = 1'b1;
          pulse_cal();
          cmd_flush = 1'b0;
          wait_state(3'd5, 80, "rnd_cal_wait");
          if ($urandom_range(0, 5) != 0) begin
            cal_busy = 2'($urandom_range(1, 3));
            step(int'($urandom_range(1, 40)));
            cal_busy = 2'b00;
          end
          step(int'($urandom_range(0, 5)));
        end
        3: begin
          cmd_sync_mode = 1'($urandom_range(0, 1));
          test_enable   = 1'($urandom_range(0, 1));
          step(int'($urandom_range(1, 8)));
        end
        default: begin
          wait_home(1200, "rnd_noise_home");
          cal_busy = 2'($urandom_range(1, 3));
          step(int'($urandom_range(1, 3)));
          cal_busy = 2'b00;
        end
      endcase
    end
    wait_home(1200, "final_home");
    step(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
